ff_en_arbiter: RTL and testbench
================================

# ff_en_arbiter

Round-robin arbiter and write sequencer that shares one `ff_en` enabled register among `NUM_REQ` requesters. Each cycle it selects at most one requester, drives that requester's word onto the register's `d_in`, pulses `d_en` for one cycle, and returns a one-cycle grant. It sits directly in front of `ff_en` and is the only block allowed to drive that register's `d_in` and `d_en`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 10: data width; matches the `ff_en` register width.
- `MAX_BURST`, 4: maximum consecutive locked writes by one owner, 1..15.
- `clock` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: per-requester write request; level, held until granted.
- `lock` in NUM_REQ: per-requester burst-lock request, qualified by `req`.
- `req_data` in NUM_REQ*DATA_W: requester i's word is at bits [i*DATA_W +: DATA_W].
- `gnt` out NUM_REQ: one-hot, one-cycle grant; the write for that requester is on `d_in`/`d_en` in the same cycle.
- `d_in` out DATA_W: data to `ff_en`.
- `d_en` out 1: write enable to `ff_en`.
- `owner` out clog2(NUM_REQ): index of the last granted requester.
- `busy` out 1: high while in BURST.

## Operation
- Reset values: `gnt`=0, `d_en`=0, `d_in`=0, `owner`=0, `busy`=0, rotation pointer `ptr`=0, `burst_cnt`=0, state=IDLE.
- Selection: the winner is the first `req[i]` set, scanning i = ptr, ptr+1, … modulo NUM_REQ.
- Grant: on the edge where a winner exists, register `gnt`=onehot(winner), `d_in`=req_data[winner], `d_en`=1, `owner`=winner. With no winner, `gnt`=0 and `d_en`=0; `d_in` holds its last value.
- Pointer: after a non-burst grant, `ptr` = (winner+1) mod NUM_REQ. Wrap-around from NUM_REQ-1 to 0 is required.
- States:
  - IDLE: no grant issued last cycle.
  - GRANT: a single write was issued.
  - BURST: the owner holds the resource.
- Transitions:
  - IDLE or GRANT to GRANT: a winner exists without `lock`.
  - IDLE or GRANT to BURST: the winner has `lock`; `burst_cnt` is set to 1.
  - Any state to IDLE: no `req` is set.
- BURST rules:
  - While `req[owner]` is set and `burst_cnt` < MAX_BURST, `owner` wins regardless of `ptr`, and `burst_cnt` increments.
  - When `req[owner]` drops, or `burst_cnt` reaches MAX_BURST, `ptr` = owner+1 and normal selection resumes on the same edge. There are no idle cycles if others are requesting.
- Deassertion: a requester sampling `gnt[i]`=1 deasserts `req[i]` on the next edge or presents the next word. A held `req` is treated as a new request.
- Simultaneous requests: exactly one grant per cycle. `gnt` is always one-hot or zero.
- Reset mid-burst: all state returns to reset values immediately (asynchronous). Outputs are low until the first edge after `rst` releases.

## Timing
- Request to grant: `req`/`req_data` sampled at edge k; `gnt`/`d_en`/`d_in` valid from edge k to edge k+1.
- `ff_en` captures `d_in` at edge k+1; its `d_out` updates after edge k+1.
- Throughput: one write per cycle, sustained across different requesters.
- `req_data` must be stable at the sampling edge only.

## Configuration
- `FF_EN_ARB_LOCK_EN` defined: `lock` and BURST behave as described.
- Undefined:
  - `lock` is ignored; there is no BURST state, no `burst_cnt`, and `busy` is tied to 0.
  - Every grant rotates `ptr`.

## Structure
- Shared package `ff_en_arb_pkg`:
  - state enum: IDLE, GRANT, BURST.
  - width helper `OWNER_W` = clog2(NUM_REQ).
  - default constants for DATA_W and MAX_BURST.
- One sub-module, `rr_pick`: a combinational rotate-priority encoder taking `req`, `ptr` and producing the winner index plus a valid flag. The FSM and output registers live in the top module.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `req`=4'b1111 → `gnt`=0, `d_en`=0, `d_in`=10'h000; the first grant after release goes to requester 0.
- Single request: `req`=4'b0100, data 10'h155 → next cycle `gnt`=4'b0100, `d_in`=10'h155, `d_en`=1; `ff_en` `d_out`=10'h155 one cycle later.
- Round-robin: `req`=4'b1111 held with data 10'h3ff, 10'h288, 10'h155, 10'h000 → grants 0,1,2,3,0 on consecutive cycles; `d_in` follows, with wrap from 3 to 0.
- Burst cap with lock enabled: requester 1 has `lock` and `req` held, requester 2 has `req` held, MAX_BURST=4 → four grants to 1, then a grant to 2, then 1 again; `busy`=1 during the four grants.
- Early release: requester 3 is locked and drops `req` after 2 grants while requester 0 requests → the next cycle grants 0 and `busy`=0.
- Reset mid-burst: assert `rst` low during the second burst write → `gnt`, `d_en`, and `busy` go to 0 immediately; after release, selection restarts from `ptr`=0.

Source files
------------

// File: rtl/ff_en_arbiter_pkg.sv
// ff_en_arb_pkg: types and constants shared by the ff_en_arbiter slice.
//   arb_state_e   : arbiter FSM state (IDLE, GRANT, BURST)
//   DATA_W_DEF    : default data width, matches the ff_en register
//   MAX_BURST_DEF : default cap on consecutive locked writes
//   CNT_W         : width of the burst counter (MAX_BURST is at most 15)
//   owner_w()     : width of a requester index, clog2(NUM_REQ), at least 1
package ff_en_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } arb_state_e;

    localparam int DATA_W_DEF    = 10;
    localparam int MAX_BURST_DEF = 4;
    localparam int CNT_W         = 4;

    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ff_en_arbiter_if.sv
// ff_en_arb_if: requester-side bus of the ff_en write arbiter.
//   req/lock/req_data : driven by the requesters (master modport)
//   gnt/d_in/d_en     : grant and the write presented to the ff_en register
//   owner/busy        : last granted index and burst-in-progress flag
//
// Handshake: req[i] is a level request that stays high until gnt[i] is seen.
// gnt[i] is a one-cycle pulse; in the cycle it is high, d_in/d_en carry that
// requester's word. A requester that still has req[i] high on the following
// edge is making a new request (its next word), not a continuation.
interface ff_en_arb_if
    import ff_en_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF
);
    localparam int OWNER_W = owner_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         d_in;
    logic                      d_en;
    logic [OWNER_W-1:0]        owner;
    logic                      busy;

    modport master (
        output req, lock, req_data,
        input  gnt, d_in, d_en, owner, busy
    );

    modport slave (
        input  req, lock, req_data,
        output gnt, d_in, d_en, owner, busy
    );

endinterface

// File: rtl/ff_en_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
//   req : request vector
//   ptr : index scanned first; scan order is ptr, ptr+1, ... modulo NUM_REQ
//   win : index of the first set request in scan order
//   vld : at least one request is set
module rr_pick
    import ff_en_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int OWNER_W = owner_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWNER_W-1:0] ptr,
    output logic [OWNER_W-1:0] win,
    output logic               vld
);

    int idx;

    // Walk the scan order backwards so the earliest hit is written last.
    always_comb begin
        win = '0;
        vld = 1'b0;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                win = OWNER_W'(idx);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ff_en_arbiter.sv
// ff_en_arbiter: round-robin arbiter and write sequencer in front of one
// ff_en register. Picks at most one requester per cycle, registers its word
// onto d_in with a one-cycle d_en and gnt pulse.
//   clock     : rising-edge clock
//   rst       : asynchronous active-low reset
//   bus       : ff_en_arb_if slave modport (req/lock/req_data in,
//               gnt/d_in/d_en/owner/busy out)
//   state_dbg : current FSM state
// Build option: define FF_EN_ARB_LOCK_EN to enable lock/BURST handling; when
// undefined, lock is ignored, every grant rotates the pointer, busy is 0.
module ff_en_arbiter
    import ff_en_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic       clock,
    input  logic       rst,
    ff_en_arb_if.slave bus,
    output arb_state_e state_dbg
);

    localparam int OWNER_W = owner_w(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [OWNER_W-1:0] ptr_q, ptr_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [DATA_W-1:0]  d_in_q, d_in_d;
    logic               d_en_q, d_en_d;

    logic [OWNER_W-1:0] sel_ptr;
    logic [OWNER_W-1:0] pick_idx;
    logic               pick_vld;
    logic [OWNER_W-1:0] grant_idx;
    logic               do_grant;

`ifdef FF_EN_ARB_LOCK_EN
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               burst_keep;
`else
    logic               unused_lock;
    localparam int UNUSED_MAX_BURST = MAX_BURST;
    assign unused_lock = ^bus.lock;
`endif

    function automatic logic [OWNER_W-1:0] next_idx(input logic [OWNER_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Leaving a burst resumes the scan just after the owner, on the same edge.
    always_comb begin
        sel_ptr = ptr_q;
`ifdef FF_EN_ARB_LOCK_EN
        if (state_q == BURST) begin
            sel_ptr = next_idx(owner_q);
        end
`endif
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OWNER_W (OWNER_W)
    ) u_pick (
        .req (bus.req),
        .ptr (sel_ptr),
        .win (pick_idx),
        .vld (pick_vld)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        gnt_d     = '0;
        d_in_d    = d_in_q;
        d_en_d    = 1'b0;
        do_grant  = 1'b0;
        grant_idx = pick_idx;
`ifdef FF_EN_ARB_LOCK_EN
        burst_cnt_d = burst_cnt_q;
        burst_keep  = (state_q == BURST) && bus.req[owner_q] &&
                      (burst_cnt_q < CNT_W'(MAX_BURST));
        if (burst_keep) begin
            // Owner keeps the register; the pointer is left untouched.
            do_grant    = 1'b1;
            grant_idx   = owner_q;
            state_d     = BURST;
            burst_cnt_d = burst_cnt_q + 1'b1;
        end else
`endif
        if (pick_vld) begin
            do_grant = 1'b1;
            ptr_d    = next_idx(pick_idx);
            state_d  = GRANT;
`ifdef FF_EN_ARB_LOCK_EN
            burst_cnt_d = '0;
            if (bus.lock[pick_idx]) begin
                state_d     = BURST;
                burst_cnt_d = CNT_W'(1);
            end
`endif
        end else begin
            // sel_ptr already holds owner+1 if a burst just ended.
            state_d = IDLE;
            ptr_d   = sel_ptr;
`ifdef FF_EN_ARB_LOCK_EN
            burst_cnt_d = '0;
`endif
        end

        if (do_grant) begin
            gnt_d[grant_idx] = 1'b1;
            d_in_d           = bus.req_data[grant_idx*DATA_W +: DATA_W];
            d_en_d           = 1'b1;
            owner_d          = grant_idx;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
            d_in_q  <= '0;
            d_en_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
            d_in_q  <= d_in_d;
            d_en_q  <= d_en_d;
        end
    end

`ifdef FF_EN_ARB_LOCK_EN
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign bus.busy = (state_q == BURST);
`else
    assign bus.busy = 1'b0;
`endif

    assign bus.gnt   = gnt_q;
    assign bus.d_in  = d_in_q;
    assign bus.d_en  = d_en_q;
    assign bus.owner = owner_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ff_en_arbiter.sv
// tb_ff_en_arbiter: directed and randomized bench for ff_en_arbiter, with a
// queue/integer reference model of the arbitration rules and a model of the
// downstream ff_en register.
module tb_ff_en_arbiter;
    import ff_en_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 10;
    localparam int MB = 4;

`ifdef FF_EN_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
    int burst_seq  [6] = '{1, 1, 1, 1, 2, 1};
    int burst_busy [6] = '{1, 1, 1, 1, 0, 1};
    int rel_busy   [3] = '{1, 1, 0};
`else
    localparam bit LOCK_ON = 1'b0;
    int burst_seq  [6] = '{1, 2, 1, 2, 1, 2};
    int burst_busy [6] = '{0, 0, 0, 0, 0, 0};
    int rel_busy   [3] = '{0, 0, 0};
`endif
    int rr_seq  [5] = '{0, 1, 2, 3, 0};
    int rel_seq [3] = '{3, 3, 0};

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    ff_en_arb_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();
    arb_state_e state_dbg;

    ff_en_arbiter #(
        .NUM_REQ   (N),
        .DATA_W    (DW),
        .MAX_BURST (MB)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Downstream ff_en register fed by the arbiter.
    logic [DW-1:0] ff_q;
    always @(posedge clock or negedge rst) begin
        if (!rst)          ff_q <= '0;
        else if (bus.d_en) ff_q <= bus.d_in;
    end

    // ---------------- stimulus variables ----------------
    logic [N-1:0]  req_v  = '0;
    logic [N-1:0]  lock_v = '0;
    logic [DW-1:0] word_v [N];

    // ---------------- reference model / scoreboard ----------------
    int            m_ptr, m_owner, m_len;
    bit            m_burst;
    logic [N-1:0]  e_gnt;
    bit            e_d_en;
    logic [DW-1:0] e_d_in, e_reg;
    logic [DW-1:0] exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_owner = 0;
        m_len   = 0;
        m_burst = 0;
        e_gnt   = '0;
        e_d_en  = 0;
        e_d_in  = '0;
        e_reg   = '0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive();
        bus.req  = req_v;
        bus.lock = lock_v;
        for (int i = 0; i < N; i++) bus.req_data[i*DW +: DW] = word_v[i];
    endtask

    // One clock: present inputs, advance the model on the edge, compare.
    task automatic step();
        int win;
        int start;
        logic [DW-1:0] w;
        drive();
        @(posedge clock);
        if (e_d_en) e_reg = e_d_in;
        win = -1;
        if (LOCK_ON && m_burst && req_v[m_owner] && m_len < MB) begin
            win = m_owner;
            m_len++;
        end else begin
            start = m_burst ? (m_owner + 1) % N : m_ptr;
            for (int k = 0; k < N; k++)
                if (win < 0 && req_v[(start + k) % N]) win = (start + k) % N;
            m_burst = 0;
            m_len   = 0;
            if (win >= 0) begin
                m_ptr = (win + 1) % N;
                if (LOCK_ON && lock_v[win]) begin
                    m_burst = 1;
                    m_len   = 1;
                end
            end else begin
                m_ptr = start;
            end
        end
        e_gnt  = '0;
        e_d_en = 0;
        if (win >= 0) begin
            e_gnt[win] = 1'b1;
            e_d_en     = 1;
            e_d_in     = word_v[win];
            m_owner    = win;
            exp_q.push_back(word_v[win]);
        end
        #1;
        check("gnt",     32'(bus.gnt),   32'(e_gnt));
        check("d_en",    32'(bus.d_en),  32'(e_d_en));
        check("d_in",    32'(bus.d_in),  32'(e_d_in));
        check("owner",   32'(bus.owner), 32'(m_owner));
        check("busy",    32'(bus.busy),  32'(m_burst));
        check("ff_en_q", 32'(ff_q),      32'(e_reg));
        if (bus.d_en) begin
            check("sb_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check("sb_word", 32'(bus.d_in), 32'(w));
            end
        end
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        req_v  = '1;
        lock_v = '0;
        drive();
        repeat (2) @(posedge clock);
        #1;
        check("rst_gnt",   32'(bus.gnt),   32'd0);
        check("rst_d_en",  32'(bus.d_en),  32'd0);
        check("rst_d_in",  32'(bus.d_in),  32'd0);
        check("rst_owner", 32'(bus.owner), 32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        @(negedge clock);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < N; i++) word_v[i] = '0;
        drive();
        model_reset();

        // Reset with all requesting; first grant goes to requester 0.
        do_reset();
        word_v = '{10'h011, 10'h022, 10'h033, 10'h044};
        req_v  = 4'b1111;
        step();
        check("rst_first_gnt", 32'(bus.gnt), 32'b0001);

        // Single request and register capture one cycle later.
        do_reset();
        req_v     = 4'b0100;
        word_v[2] = 10'h155;
        step();
        check("single_gnt",  32'(bus.gnt),  32'b0100);
        check("single_d_in", 32'(bus.d_in), 32'h155);
        req_v = '0;
        step();
        check("single_ff_en", 32'(ff_q), 32'h155);

        // Round-robin with wrap from 3 to 0.
        do_reset();
        word_v = '{10'h3ff, 10'h288, 10'h155, 10'h000};
        req_v  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_gnt",  32'(bus.gnt),  32'(1) << rr_seq[k]);
            check("rr_d_in", 32'(bus.d_in), 32'(word_v[rr_seq[k]]));
        end

        // Burst cap: 1 locked, 2 plain.
        do_reset();
        req_v  = 4'b0110;
        lock_v = 4'b0010;
        word_v = '{10'h001, 10'h0a1, 10'h0b2, 10'h003};
        for (int k = 0; k < 6; k++) begin
            step();
            check("burst_gnt",  32'(bus.gnt),  32'(1) << burst_seq[k]);
            check("burst_busy", 32'(bus.busy), 32'(burst_busy[k]));
        end

        // Early release: 3 locked drops req after two grants, 0 waiting.
        do_reset();
        lock_v = 4'b1000;
        word_v = '{10'h1c0, 10'h000, 10'h000, 10'h2e3};
        for (int k = 0; k < 3; k++) begin
            req_v = (k < 2) ? 4'b1000 : 4'b0001;
            step();
            check("rel_gnt",  32'(bus.gnt),  32'(1) << rel_seq[k]);
            check("rel_busy", 32'(bus.busy), 32'(rel_busy[k]));
        end

        // Reset asserted during the second burst write.
        do_reset();
        req_v  = 4'b0010;
        lock_v = 4'b0010;
        word_v = '{10'h10f, 10'h2f0, 10'h0ff, 10'h301};
        step();
        drive();
        @(posedge clock);
        #3;
        rst = 1'b0;
        #1;
        check("midrst_gnt",  32'(bus.gnt),  32'd0);
        check("midrst_d_en", 32'(bus.d_en), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        @(negedge clock);
        rst = 1'b1;
        model_reset();
        req_v  = 4'b1111;
        lock_v = '0;
        step();
        check("midrst_restart", 32'(bus.gnt), 32'b0001);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) != 0) req_v = N'($urandom_range(0, 15));
            lock_v = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) word_v[i] = DW'($urandom_range(0, 1023));
            step();
        end
        req_v = '0;
        step();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
